jogador_automatico: RTL and testbench

Automatic player for the memory-game circuit: it watches the `leds` sequence the game presents, stores it, and replays it on `chaves` when `vez_jogador` is asserted. Each press is held and released with fixed cycle timing. It sits between the game's output and input pins, which closes the loop for self-test on the FPGA and for long regression runs without a hand-written stimulus task. An injectable deliberate mistake exercises the game's `errou` path.

---
 rtl/jogador_pkg.sv | 26 ++
 rtl/jogador_memoria.sv | 21 ++
 rtl/jogador_automatico.sv | 176 +++++++++++++++++
 tb/tb_jogador_automatico.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/jogador_pkg.sv
// Shared definitions for the automatic memory-game player: state encoding,
// debug code map and the deliberate-mistake press value.
package jogador_pkg;

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CAPTURA   = 4'd1,
    ESPERA    = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    AGUARDA   = 4'd5,
    FIM       = 4'd6
  } estado_t;

  function automatic logic [3:0] codigo_estado(input estado_t e);
    return 4'(e);
  endfunction

  // Rotate-left by one; a zero result would be a non-press, so force colour 0.
  function automatic logic [3:0] valor_erro(input logic [3:0] v);
    logic [3:0] r;
    r = {v[2:0], v[3]};
    return (r == 4'b0) ? 4'b0001 : r;
  endfunction

endpackage

// File: rtl/jogador_memoria.sv
// Play store: DEPTH x 4 register file, synchronous write, asynchronous read.
module jogador_memoria #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [3:0]    rdata
);

  logic [DEPTH-1:0][3:0] mem;

  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player: captures the presented leds sequence, then replays it on
// chaves with fixed gap/hold timing when the game hands over the turn.
module jogador_automatico
  import jogador_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int HOLD  = 3,
  parameter int GAP   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       vez_jogador,
  input  logic       pronto,
  input  logic       injetar_erro,
  output logic [3:0] chaves,
  output logic       jogando,
  output logic       estouro,
  output logic [3:0] db_estado,
  output logic [3:0] db_contagem
);

  localparam int AW    = $clog2(DEPTH);
  localparam int NW    = AW + 1;
  localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW    = $clog2(MAXHG + 1);

  estado_t       estado, prox_estado;
  logic [NW-1:0] n, i, prox_n, prox_i, i_lido;
  logic [CW-1:0] cnt, prox_cnt;
  logic          erro, prox_erro, prox_estouro;
  logic [3:0]    leds_ant, prox_chaves, rd_dado, valor_press;
  logic          borda, wr_en, ultimo, fim_gap, fim_hold, replay_prox;

  assign borda = (estado == CAPTURA) && (leds != 4'b0) && (leds_ant == 4'b0);
  assign wr_en = borda && (n != NW'(DEPTH));

  // Leaving SOLTA loads the next play, so read one slot ahead there.
  assign i_lido      = (estado == SOLTA) ? i + NW'(1) : i;
  assign ultimo      = erro && (i_lido == n - NW'(1));
  assign valor_press = ultimo ? valor_erro(rd_dado) : rd_dado;

  assign fim_gap  = (cnt == CW'(GAP - 1));
  assign fim_hold = (cnt == CW'(HOLD - 1));

  jogador_memoria #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clock (clock),
    .we    (wr_en),
    .waddr (n[AW-1:0]),
    .wdata (leds),
    .raddr (i_lido[AW-1:0]),
    .rdata (rd_dado)
  );

  always_comb begin
    prox_estado  = estado;
    prox_n       = n;
    prox_i       = i;
    prox_cnt     = cnt;
    prox_erro    = erro;
    prox_estouro = estouro;
    prox_chaves  = 4'b0;

    if (estado == OCIOSO) prox_estouro = 1'b0;
    if (borda) begin
      if (n == NW'(DEPTH)) prox_estouro = 1'b1;
      else                 prox_n       = n + NW'(1);
    end

    if (!habilitar) begin
      prox_estado = OCIOSO;
    end else if (pronto && estado != OCIOSO) begin
      prox_estado = FIM;
    end else begin
      case (estado)
        OCIOSO: begin
          prox_estado  = CAPTURA;
          prox_n       = '0;
          prox_i       = '0;
          prox_estouro = 1'b0;
        end
        CAPTURA: begin
          if (vez_jogador) begin
            if (n != '0) begin
              prox_estado = ESPERA;
              prox_i      = '0;
              prox_cnt    = '0;
              prox_erro   = injetar_erro;
            end else begin
              prox_estado = AGUARDA;
            end
          end
        end
        ESPERA, PRESSIONA, SOLTA: begin
          if (!vez_jogador) begin
            // Turn withdrawn mid-replay: drop the round like a normal exit.
            prox_estado = CAPTURA;
            prox_n      = '0;
            prox_erro   = 1'b0;
          end else if (estado == ESPERA) begin
            if (fim_gap) begin
              prox_estado = PRESSIONA;
              prox_cnt    = '0;
              prox_chaves = valor_press;
            end else begin
              prox_cnt = cnt + CW'(1);
            end
          end else if (estado == PRESSIONA) begin
            if (fim_hold) begin
              prox_estado = SOLTA;
              prox_cnt    = '0;
            end else begin
              prox_cnt    = cnt + CW'(1);
              prox_chaves = valor_press;
            end
          end else begin
            if (fim_gap) begin
              prox_cnt = '0;
              prox_i   = i + NW'(1);
              if (i + NW'(1) < n) begin
                prox_estado = PRESSIONA;
                prox_chaves = valor_press;
              end else begin
                prox_estado = AGUARDA;
              end
            end else begin
              prox_cnt = cnt + CW'(1);
            end
          end
        end
        AGUARDA: begin
          if (!vez_jogador) begin
            prox_estado = CAPTURA;
            prox_n      = '0;
            prox_erro   = 1'b0;
          end
        end
        FIM:     prox_estado = FIM;
        default: prox_estado = OCIOSO;
      endcase
    end
  end

  assign replay_prox = (prox_estado == ESPERA) || (prox_estado == PRESSIONA) ||
                       (prox_estado == SOLTA);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      n           <= '0;
      i           <= '0;
      cnt         <= '0;
      erro        <= 1'b0;
      leds_ant    <= 4'b0;
      chaves      <= 4'b0;
      jogando     <= 1'b0;
      estouro     <= 1'b0;
      db_estado   <= 4'b0;
      db_contagem <= 4'b0;
    end else begin
      estado      <= prox_estado;
      n           <= prox_n;
      i           <= prox_i;
      cnt         <= prox_cnt;
      erro        <= prox_erro;
      leds_ant    <= leds;
      chaves      <= prox_chaves;
      jogando     <= replay_prox;
      estouro     <= prox_estouro;
      db_estado   <= codigo_estado(prox_estado);
      db_contagem <= replay_prox ? 4'(prox_i) : 4'(prox_n);
    end
  end

endmodule

// File: tb/tb_jogador_automatico.sv
// Randomized and directed bench for jogador_automatico against a sequence-level
// model: captured plays in a queue, press waveform derived from gap/hold arithmetic.
module tb_jogador_automatico;

  localparam int DEPTH = 16;
  localparam int HOLD  = 3;
  localparam int GAP   = 3;
  localparam int PER   = HOLD + GAP;

  logic       clock = 1'b0;
  logic       reset, habilitar, vez_jogador, pronto, injetar_erro;
  logic [3:0] leds;
  logic [3:0] chaves, db_estado, db_contagem;
  logic       jogando, estouro;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] capt[$];
  bit         exp_estouro = 1'b0;

  always #5 clock = ~clock;

  jogador_automatico #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(GAP)) dut (
    .clock        (clock),
    .reset        (reset),
    .habilitar    (habilitar),
    .leds         (leds),
    .vez_jogador  (vez_jogador),
    .pronto       (pronto),
    .injetar_erro (injetar_erro),
    .chaves       (chaves),
    .jogando      (jogando),
    .estouro      (estouro),
    .db_estado    (db_estado),
    .db_contagem  (db_contagem)
  );

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, esp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] rot(input logic [3:0] v);
    logic [3:0] r;
    r = ((v << 1) | (v >> 3)) & 4'hF;
    return (r == 4'h0) ? 4'h1 : r;
  endfunction

  task automatic pulso(input logic [3:0] v, input int larg, input int gap);
    leds = v;
    repeat (larg) tick;
    leds = 4'h0;
    repeat (gap) tick;
    if (capt.size() < DEPTH) capt.push_back(v);
    else exp_estouro = 1'b1;
  endtask

  function automatic logic [3:0] cor_aleatoria;
    logic [3:0] v;
    if ($urandom_range(0, 4) == 0) v = 4'($urandom_range(1, 15));
    else v = 4'(1 << $urandom_range(0, 3));
    return v;
  endfunction

  // modo 0: full round; 1: turn withdrawn at t==corte; 2: pronto at t==corte;
  // 3: async reset pulse between edges at t==corte.
  task automatic rodada(input bit erro, input int modo, input int corte);
    int n, T, jog, p, r, est;
    logic [3:0] esp;
    logic [3:0] press[$];
    n = capt.size();
    press = capt;
    if (erro) press[n-1] = rot(press[n-1]);
    verifica("n_capturado", db_contagem, n % 16);
    verifica("estouro_antes", estouro, exp_estouro);
    verifica("estado_captura", db_estado, 1);
    injetar_erro = erro;
    vez_jogador  = 1'b1;
    T   = GAP + n * PER;
    jog = 0;
    for (int t = 0; t < T; t++) begin
      tick;
      p   = (t < GAP) ? 0 : (t - GAP) / PER;
      r   = (t < GAP) ? 0 : (t - GAP) % PER;
      esp = (t >= GAP && r < HOLD) ? press[p] : 4'h0;
      est = (t < GAP) ? 2 : ((r < HOLD) ? 3 : 4);
      verifica("chaves", chaves, esp);
      verifica("jogando", jogando, 1);
      verifica("db_estado_replay", db_estado, est);
      verifica("db_contagem_replay", db_contagem, p % 16);
      jog += int'(jogando);
      if (modo != 0 && t == corte) begin
        if (modo == 1) begin
          vez_jogador = 1'b0;
          tick;
          verifica("aborta_chaves", chaves, 0);
          verifica("aborta_estado", db_estado, 1);
          verifica("aborta_n", db_contagem, 0);
          verifica("aborta_jogando", jogando, 0);
        end else if (modo == 2) begin
          pronto = 1'b1;
          tick;
          verifica("fim_estado", db_estado, 6);
          verifica("fim_chaves", chaves, 0);
          verifica("fim_jogando", jogando, 0);
          pronto      = 1'b0;
          vez_jogador = 1'b0;
          tick;
          verifica("fim_retido", db_estado, 6);
          habilitar = 1'b0;
          tick;
          verifica("ocioso_estado", db_estado, 0);
          tick;
          verifica("ocioso_estouro", estouro, 0);
          habilitar = 1'b1;
          tick;
          verifica("reinicio_estado", db_estado, 1);
          exp_estouro = 1'b0;
        end else begin
          #2 reset = 1'b1;
          vez_jogador = 1'b0;
          #1;
          verifica("reset_async_chaves", chaves, 0);
          verifica("reset_async_estado", db_estado, 0);
          verifica("reset_async_jogando", jogando, 0);
          tick;
          reset = 1'b0;
          tick;
          verifica("pos_reset_estado", db_estado, 1);
          verifica("pos_reset_estouro", estouro, 0);
          exp_estouro = 1'b0;
        end
        injetar_erro = 1'b0;
        vez_jogador  = 1'b0;
        capt.delete();
        return;
      end
    end
    tick;
    verifica("aguarda_estado", db_estado, 5);
    verifica("aguarda_chaves", chaves, 0);
    verifica("aguarda_jogando", jogando, 0);
    verifica("aguarda_contagem", db_contagem, n % 16);
    verifica("jogando_ciclos", jog, T);
    vez_jogador  = 1'b0;
    injetar_erro = 1'b0;
    tick;
    verifica("volta_captura", db_estado, 1);
    verifica("volta_n", db_contagem, 0);
    capt.delete();
  endtask

  task automatic rodada_aleatoria(input int max_len);
    int len;
    len = $urandom_range(1, max_len);
    for (int k = 0; k < len; k++)
      pulso(cor_aleatoria(), $urandom_range(1, 4), $urandom_range(1, 3));
    rodada(1'($urandom_range(0, 1)), 0, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary forced");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; habilitar = 1'b0; leds = 4'h0;
    vez_jogador = 1'b0; pronto = 1'b0; injetar_erro = 1'b0;
    repeat (2) tick;
    verifica("rst_chaves", chaves, 0);
    verifica("rst_jogando", jogando, 0);
    verifica("rst_estouro", estouro, 0);
    verifica("rst_estado", db_estado, 0);
    verifica("rst_contagem", db_contagem, 0);
    reset = 1'b0;
    tick;
    verifica("ocioso_sem_habilitar", db_estado, 0);
    habilitar = 1'b1;
    tick;
    verifica("entra_captura", db_estado, 1);

    // Round of 1
    pulso(4'b0001, 1, 2);
    rodada(1'b0, 0, -1);

    // Round of 3 with held and repeated colours
    pulso(4'b0001, 2, 1);
    pulso(4'b0010, 1, 3);
    pulso(4'b0001, 4, 1);
    rodada(1'b0, 0, -1);

    // Deliberate mistake on the last press: 0010 -> 0100
    pulso(4'b0001, 1, 1);
    pulso(4'b0010, 1, 1);
    rodada(1'b1, 0, -1);

    // Turn withdrawn during the second press
    pulso(4'b0100, 1, 1);
    pulso(4'b1000, 2, 1);
    pulso(4'b0001, 1, 2);
    rodada(1'b0, 1, GAP + PER + 1);

    for (int k = 0; k < 6; k++) rodada_aleatoria(8);

    // Overflow: one play more than the store holds
    for (int k = 0; k < DEPTH + 1; k++)
      pulso(4'(1 << (k % 4)), 1, 1);
    rodada(1'b0, 0, -1);

    // pronto mid-replay, then habilitar drop and restart
    pulso(4'b0010, 1, 1);
    pulso(4'b1000, 1, 1);
    rodada(1'b0, 2, GAP + 1);

    // Async reset between edges during a press
    pulso(4'b0100, 2, 1);
    pulso(4'b0001, 1, 1);
    rodada(1'b0, 3, GAP + 1);

    rodada_aleatoria(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
